dbus_arbiter: RTL

Two-requester arbiter that shares the single data-side bus port between the fetch stage (instruction read requests, `ibus`) and the memory stage (load/store requests, `dbus`). It grants at most one transaction at a time, holds the grant from acceptance until the response completes, and routes `addr_ok`/`data_ok` back only to the owner. It sits between the pipeline stages and the bus/cache interface, directly below the memory stage's `dreq`/`dresp` port.

---
 rtl/dbus_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares the data-side bus port between fetch (ibus) and memory-stage (dbus) requests
package dbus_arbiter_pkg;
    typedef logic [2:0] msize_t;
    localparam msize_t MSIZE4 = 3'd2;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;
    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;
    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;
endpackage

module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic       clk,
    input  logic       resetn,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output dbus_req_t  oreq,
    input  dbus_resp_t oresp
);
    localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2;
    logic [1:0] state, state_nx;
    logic       own, own_nx, last_win, last_win_nx;
    logic       both, win, sel, cur_valid, route;
    dbus_req_t  ireq_ext;
    // grant selection: winner in IDLE, locked owner otherwise (1 = memory stage)
    always_comb begin
        ireq_ext  = '{valid: ireq.valid, addr: ireq.addr, size: MSIZE4, strobe: 4'h0, data: 32'h0};
        both      = ireq.valid & dreq.valid;
        win       = both ? (ROUND_ROBIN ? ~last_win : 1'b1) : dreq.valid;
        sel       = (state == IDLE) ? win : own;
        cur_valid = (state == IDLE) ? (ireq.valid | dreq.valid) :
                    (state == ADDR) ? (own ? dreq.valid : ireq.valid) : 1'b0;
        route     = cur_valid | (state == DATA);
    end
    // request forwarding and response routing, all forced to zero while in reset
    always_comb begin
        oreq          = (resetn & cur_valid) ? (sel ? dreq : ireq_ext) : '0;
        iresp.addr_ok = resetn & route & ~sel & oresp.addr_ok;
        iresp.data_ok = resetn & route & ~sel & oresp.data_ok;
        iresp.data    = resetn ? oresp.data : 32'h0;
        dresp.addr_ok = resetn & route & sel & oresp.addr_ok;
        dresp.data_ok = resetn & route & sel & oresp.data_ok;
        dresp.data    = resetn ? oresp.data : 32'h0;
    end
    // next-state: hold the grant from issue until data_ok, drop it if the owner withdraws
    always_comb begin
        state_nx    = state;
        own_nx      = own;
        last_win_nx = last_win;
        if (state == IDLE) begin
            if (cur_valid) begin
                own_nx   = win;
                state_nx = oresp.addr_ok ? (oresp.data_ok ? IDLE : DATA) : ADDR;
            end
            if (both) last_win_nx = win;
        end else if (state == ADDR) begin
            state_nx = !cur_valid ? IDLE : oresp.addr_ok ? (oresp.data_ok ? IDLE : DATA) : ADDR;
        end else begin
            state_nx = oresp.data_ok ? IDLE : DATA;
        end
    end
    // state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            own      <= 1'b0;
            last_win <= 1'b0;
        end else begin
            state    <= state_nx;
            own      <= own_nx;
            last_win <= last_win_nx;
        end
    end
endmodule
